// File: rtl/i2c_cmd_arbiter_if.sv
// Command-arbiter bus bundle: requester side (req/data/grant/done/err) and
// I2C master side (start/data/busy/done/nack) of i2c_cmd_arbiter.
//   master : view taken by the arbiter (drives grants, pulses, start, word, busy_o)
//   slave  : view taken by the requesters / I2C master environment
interface i2c_cmd_arbiter_if #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned DATA_W = 16
);
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ*DATA_W-1:0] data_i;
    logic [N_REQ-1:0]        gnt_o;
    logic [N_REQ-1:0]        done_o;
    logic [N_REQ-1:0]        err_o;
    logic                    i2c_start_o;
    logic [DATA_W-1:0]       i2c_data_o;
    logic                    i2c_busy_i;
    logic                    i2c_done_i;
    logic                    i2c_nack_i;
    logic                    busy_o;

    modport master (
        input  req_i, data_i, i2c_busy_i, i2c_done_i, i2c_nack_i,
        output gnt_o, done_o, err_o, i2c_start_o, i2c_data_o, busy_o
    );

    modport slave (
        output req_i, data_i, i2c_busy_i, i2c_done_i, i2c_nack_i,
        input  gnt_o, done_o, err_o, i2c_start_o, i2c_data_o, busy_o
    );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C master between N_REQ command requesters.
// The granted requester's command word is latched and launched; a NACK is
// retried up to MAX_RETRY times, a missing completion times out after TIMEOUT
// cycles in WAIT. One done_o or err_o pulse is returned per transaction.
// Ports:
//   clk_i2c  : I2C-domain clock
//   reg_rstn : asynchronous active-low reset
//   bus      : i2c_cmd_arbiter_if.master (requester and I2C master signals)
module i2c_cmd_arbiter #(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic                clk_i2c,
    input  logic                reg_rstn,
    i2c_cmd_arbiter_if.master   bus
);
    localparam int unsigned IDX_W = (N_REQ > 1)     ? $clog2(N_REQ)       : 1;
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;
    localparam int unsigned TMO_W = (TIMEOUT > 0)   ? $clog2(TIMEOUT+1)   : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] last_gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic [RTY_W-1:0] retry_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic [IDX_W-1:0] win_idx;
    logic             win_vld;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            if (!win_vld && bus.req_i[(32'(last_gnt) + i) % N_REQ]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'((32'(last_gnt) + i) % N_REQ);
            end
        end
    end

    // Arbitration / transfer FSM with registered outputs.
    always_ff @(posedge clk_i2c or negedge reg_rstn) begin
        if (!reg_rstn) begin
            state           <= IDLE;
            last_gnt        <= IDX_W'(N_REQ - 1);
            gnt_idx         <= '0;
            retry_cnt       <= '0;
            tmo_cnt         <= '0;
            bus.gnt_o       <= '0;
            bus.done_o      <= '0;
            bus.err_o       <= '0;
            bus.i2c_start_o <= 1'b0;
            bus.i2c_data_o  <= '0;
            bus.busy_o      <= 1'b0;
        end else begin
            bus.done_o      <= '0;
            bus.err_o       <= '0;
            bus.i2c_start_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld && !bus.i2c_busy_i) begin
                        gnt_idx         <= win_idx;
                        bus.gnt_o       <= N_REQ'(1) << win_idx;
                        bus.i2c_data_o  <= bus.data_i[32'(win_idx) * DATA_W +: DATA_W];
                        retry_cnt       <= '0;
                        bus.i2c_start_o <= 1'b1;
                        bus.busy_o      <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                    // A completion beats a timeout landing in the same cycle.
                    if (bus.i2c_done_i) begin
                        if (!bus.i2c_nack_i) begin
                            bus.done_o <= bus.gnt_o;
                            state      <= RESP;
                        end else if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                            retry_cnt       <= retry_cnt + RTY_W'(1);
                            bus.i2c_start_o <= 1'b1;
                            state           <= ISSUE;
                        end else begin
                            bus.err_o <= bus.gnt_o;
                            state     <= RESP;
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
                        bus.err_o <= bus.gnt_o;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    last_gnt   <= gnt_idx;
                    bus.gnt_o  <= '0;
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
